// File: rtl/turf_hold_manager.sv
// rtl/turf_hold_manager.sv - HOLD buffer allocator with post-trigger delay, deadtime and reject accounting
module turf_hold_manager #(
  parameter int NUM_SURFS  = 12,
  parameter int NUM_HOLD   = 4,
  parameter int HOLD_DELAY = 8,
  parameter int DEADTIME   = 16
) (
  input  logic                          CLK125,
  input  logic                          reset_i,
  input  logic                          trig_i,
  input  logic [NUM_HOLD-1:0]           clear_i,
  output logic [NUM_HOLD*NUM_SURFS-1:0] HOLD,
  output logic [NUM_HOLD-1:0]           hold_status_o,
  output logic                          trig_accept_o,
  output logic [1:0]                    trig_buffer_o,
  output logic                          trig_reject_o,
  output logic                          busy_o,
  output logic [15:0]                   reject_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_LATCH, S_DEAD} state_t;

  localparam logic [7:0] DELAY_LAST = 8'(HOLD_DELAY - 1);
  localparam logic [7:0] DEAD_LAST  = 8'(DEADTIME - 1);

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic [NUM_HOLD-1:0] r_hold;
  logic [NUM_HOLD-1:0] r_reserved;
  logic [1:0]          r_res_idx;
  logic [1:0]          r_next_ptr;
  logic                r_accept;
  logic [1:0]          r_buffer;
  logic                r_reject;
  logic                r_busy;
  logic [15:0]         r_reject_count;

  logic [NUM_HOLD-1:0] w_free;
  logic [NUM_HOLD-1:0] w_hold_nxt;
  logic [NUM_HOLD-1:0] w_res_nxt;
  logic                w_alloc_ok;
  logic [1:0]          w_alloc_idx;
  logic [1:0]          w_cand;
  logic                w_accept;
  logic                w_reject;

  // Free status is taken from the registered state, so a clear on this edge
  // cannot satisfy a trigger sampled on the same edge.
  always_comb begin
    w_free      = ~(r_hold | r_reserved);
    w_alloc_ok  = 1'b0;
    w_alloc_idx = r_next_ptr;
    w_cand      = r_next_ptr;
    for (int i = NUM_HOLD - 1; i >= 0; i--) begin
      w_cand = r_next_ptr + 2'(i);
      if (w_free[w_cand]) begin
        w_alloc_ok  = 1'b1;
        w_alloc_idx = w_cand;
      end
    end
    w_accept   = (r_state == S_IDLE) && trig_i && w_alloc_ok;
    w_reject   = trig_i && !w_accept;
    w_hold_nxt = r_hold & ~clear_i;
    w_res_nxt  = r_reserved;
    if (r_state == S_LATCH) begin
      w_hold_nxt[r_res_idx] = 1'b1;
      w_res_nxt             = '0;
    end
    if (w_accept) begin
      w_res_nxt[w_alloc_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK125) begin
    if (reset_i) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_hold         <= '0;
      r_reserved     <= '0;
      r_res_idx      <= '0;
      r_next_ptr     <= '0;
      r_accept       <= 1'b0;
      r_buffer       <= '0;
      r_reject       <= 1'b0;
      r_busy         <= 1'b0;
      r_reject_count <= '0;
    end else begin
      r_hold     <= w_hold_nxt;
      r_reserved <= w_res_nxt;
      r_busy     <= &(w_hold_nxt | w_res_nxt);
      r_accept   <= 1'b0;
      r_reject   <= w_reject;
      if (w_reject && (r_reject_count != 16'hFFFF)) begin
        r_reject_count <= r_reject_count + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_res_idx  <= w_alloc_idx;
            r_next_ptr <= w_alloc_idx + 2'd1;
            r_cnt      <= '0;
            r_state    <= (HOLD_DELAY == 0) ? S_LATCH : S_DELAY;
          end
        end
        S_DELAY: begin
          if (r_cnt == DELAY_LAST) begin
            r_state <= S_LATCH;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_LATCH: begin
          r_accept <= 1'b1;
          r_buffer <= r_res_idx;
          r_cnt    <= '0;
          r_state  <= (DEADTIME == 0) ? S_IDLE : S_DEAD;
        end
        S_DEAD: begin
          if (r_cnt == DEAD_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hold_status_o  = r_hold;
  assign HOLD           = {NUM_SURFS{r_hold}};
  assign trig_accept_o  = r_accept;
  assign trig_buffer_o  = r_buffer;
  assign trig_reject_o  = r_reject;
  assign busy_o         = r_busy;
  assign reject_count_o = r_reject_count;

endmodule

// File: tb/tb_turf_hold_manager.sv
// tb/tb_turf_hold_manager.sv - self-checking bench for turf_hold_manager
module tb_turf_hold_manager;

  localparam int NS = 12;
  localparam int NH = 4;
  localparam int D  = 8;
  localparam int T  = 16;

  logic          CLK125 = 1'b0;
  logic          reset_i = 1'b0;
  logic          trig_i = 1'b0;
  logic [NH-1:0] clear_i = '0;
  logic [NH*NS-1:0] HOLD;
  logic [NH-1:0] hold_status_o;
  logic          trig_accept_o;
  logic [1:0]    trig_buffer_o;
  logic          trig_reject_o;
  logic          busy_o;
  logic [15:0]   reject_count_o;

  int total = 0;
  int bad   = 0;

  // Reference model: timestamps of latch and next-acceptable edge instead of a state machine
  logic [3:0]  m_held = '0;
  logic        m_res_valid = 1'b0;
  logic [1:0]  m_res_idx = '0;
  logic [1:0]  m_ptr = '0;
  logic [1:0]  m_buf = '0;
  logic        m_accept = 1'b0;
  logic        m_reject = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_count = '0;
  int          m_edge = 0;
  int          m_latch_edge = -1;
  int          m_next_ok = 0;

  turf_hold_manager #(
    .NUM_SURFS(NS), .NUM_HOLD(NH), .HOLD_DELAY(D), .DEADTIME(T)
  ) dut (
    .CLK125(CLK125), .reset_i(reset_i), .trig_i(trig_i), .clear_i(clear_i),
    .HOLD(HOLD), .hold_status_o(hold_status_o), .trig_accept_o(trig_accept_o),
    .trig_buffer_o(trig_buffer_o), .trig_reject_o(trig_reject_o),
    .busy_o(busy_o), .reject_count_o(reject_count_o)
  );

  initial forever #4 CLK125 = ~CLK125;

  task automatic model_edge(input logic rst, input logic trg, input logic [3:0] clr);
    logic [3:0] free;
    logic [3:0] resmask;
    logic       acc;
    logic [1:0] idx;
    logic [1:0] c;
    m_edge++;
    if (rst) begin
      m_held = '0; m_res_valid = 1'b0; m_res_idx = '0; m_ptr = '0; m_buf = '0;
      m_accept = 1'b0; m_reject = 1'b0; m_busy = 1'b0; m_count = '0;
      m_latch_edge = -1; m_next_ok = m_edge + 1;
    end else begin
      resmask = m_res_valid ? (4'b0001 << m_res_idx) : 4'b0000;
      free = ~(m_held | resmask);
      m_held = m_held & ~clr;
      m_accept = 1'b0;
      if (m_res_valid && (m_edge == m_latch_edge)) begin
        m_held[m_res_idx] = 1'b1;
        m_res_valid = 1'b0;
        m_buf = m_res_idx;
        m_accept = 1'b1;
      end
      acc = 1'b0;
      idx = '0;
      if (trg && (m_edge >= m_next_ok)) begin
        for (int off = 0; off < 4; off++) begin
          c = 2'((int'(m_ptr) + off) % 4);
          if (!acc && free[c]) begin
            acc = 1'b1;
            idx = c;
          end
        end
      end
      if (acc) begin
        m_res_valid = 1'b1;
        m_res_idx = idx;
        m_ptr = idx + 2'd1;
        m_latch_edge = m_edge + D + 1;
        m_next_ok = m_edge + D + 2 + T;
      end
      m_reject = trg && !acc;
      if (m_reject && (m_count != 16'hFFFF)) m_count = m_count + 16'd1;
      resmask = m_res_valid ? (4'b0001 << m_res_idx) : 4'b0000;
      m_busy = &(m_held | resmask);
    end
  endtask

  task automatic step(input logic rst, input logic trg, input logic [3:0] clr);
    reset_i = rst;
    trig_i  = trg;
    clear_i = clr;
    @(posedge CLK125);
    model_edge(rst, trg, clr);
    #1;
    reset_i = 1'b0;
    trig_i  = 1'b0;
    clear_i = '0;
  endtask

  task automatic fill_all();
    step(1'b1, 1'b0, 4'b0);
    for (int b = 0; b < 4; b++) begin
      step(1'b0, 1'b1, 4'b0);
      repeat (D + T + 1) step(1'b0, 1'b0, 4'b0);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 4'b0);
    total++;
    if ({HOLD, hold_status_o, trig_accept_o, trig_buffer_o, trig_reject_o, busy_o, reject_count_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got hold=%h acc=%b buf=%0d rej=%b busy=%b cnt=%0d, want all 0",
               hold_status_o, trig_accept_o, trig_buffer_o, trig_reject_o, busy_o, reject_count_o);
    end
  endtask

  task automatic test_first_trigger();
    step(1'b1, 1'b0, 4'b0);
    for (int e = 1; e <= 22; e++) begin
      step(1'b0, (e == 10), 4'b0);
      if (e == 18) begin
        total++;
        if (hold_status_o !== 4'b0000 || trig_accept_o !== 1'b0) begin
          bad++;
          $display("FAIL first_early: got hold=%b acc=%b, want 0000/0", hold_status_o, trig_accept_o);
        end
      end
      if (e == 19) begin
        total++;
        if (HOLD !== {NS{4'b0001}}) begin
          bad++;
          $display("FAIL first_hold_vec: got %h want %h", HOLD, {NS{4'b0001}});
        end
        total++;
        if (trig_accept_o !== 1'b1 || trig_buffer_o !== 2'd0) begin
          bad++;
          $display("FAIL first_accept: got acc=%b buf=%0d want 1/0", trig_accept_o, trig_buffer_o);
        end
      end
      if (e == 20) begin
        total++;
        if (trig_accept_o !== 1'b0) begin
          bad++;
          $display("FAIL first_pulse_width: got acc=%b want 0", trig_accept_o);
        end
      end
    end
  endtask

  task automatic test_fill_reject();
    step(1'b1, 1'b0, 4'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 4'b0);
      if (k == 4) begin
        total++;
        if (trig_reject_o !== 1'b1 || reject_count_o !== 16'd1) begin
          bad++;
          $display("FAIL fill_fifth_reject: got rej=%b cnt=%0d want 1/1", trig_reject_o, reject_count_o);
        end
      end
      for (int j = 1; j < 30; j++) begin
        step(1'b0, 1'b0, 4'b0);
        if (j == D + 1 && k < 4) begin
          total++;
          if (trig_accept_o !== 1'b1 || trig_buffer_o !== 2'(k)) begin
            bad++;
            $display("FAIL fill_buf%0d: got acc=%b buf=%0d want 1/%0d", k, trig_accept_o, trig_buffer_o, k);
          end
        end
      end
    end
    total++;
    if (busy_o !== 1'b1 || hold_status_o !== 4'b1111) begin
      bad++;
      $display("FAIL fill_busy: got busy=%b hold=%b want 1/1111", busy_o, hold_status_o);
    end
  endtask

  task automatic test_clear_realloc();
    step(1'b0, 1'b0, 4'b0100);
    total++;
    if (hold_status_o !== 4'b1011 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL clear2_release: got hold=%b busy=%b want 1011/0", hold_status_o, busy_o);
    end
    step(1'b0, 1'b0, 4'b0);
    step(1'b0, 1'b1, 4'b0);
    repeat (D) step(1'b0, 1'b0, 4'b0);
    step(1'b0, 1'b0, 4'b0);
    total++;
    if (trig_accept_o !== 1'b1 || trig_buffer_o !== 2'd2 || hold_status_o !== 4'b1111) begin
      bad++;
      $display("FAIL clear2_realloc: got acc=%b buf=%0d hold=%b want 1/2/1111", trig_accept_o, trig_buffer_o, hold_status_o);
    end
    repeat (T + 2) step(1'b0, 1'b0, 4'b0);
    step(1'b0, 1'b0, 4'b1001);
    step(1'b0, 1'b1, 4'b0);
    repeat (D) step(1'b0, 1'b0, 4'b0);
    step(1'b0, 1'b0, 4'b0);
    total++;
    if (trig_accept_o !== 1'b1 || trig_buffer_o !== 2'd3 || hold_status_o !== 4'b1110) begin
      bad++;
      $display("FAIL next_ptr_after2: got acc=%b buf=%0d hold=%b want 1/3/1110", trig_accept_o, trig_buffer_o, hold_status_o);
    end
  endtask

  task automatic test_delay_dead_reject();
    step(1'b1, 1'b0, 4'b0);
    for (int e = 0; e <= 40; e++) begin
      step(1'b0, (e == 0 || e == 5 || e == 25 || e == 26), 4'b0);
      if (e == 5) begin
        total++;
        if (trig_reject_o !== 1'b1 || reject_count_o !== 16'd1) begin
          bad++;
          $display("FAIL reject_in_delay: got rej=%b cnt=%0d want 1/1", trig_reject_o, reject_count_o);
        end
      end
      if (e == 25) begin
        total++;
        if (trig_reject_o !== 1'b1 || reject_count_o !== 16'd2) begin
          bad++;
          $display("FAIL reject_in_dead: got rej=%b cnt=%0d want 1/2", trig_reject_o, reject_count_o);
        end
      end
      if (e == 26) begin
        total++;
        if (trig_reject_o !== 1'b0 || reject_count_o !== 16'd2) begin
          bad++;
          $display("FAIL first_ok_edge: got rej=%b cnt=%0d want 0/2", trig_reject_o, reject_count_o);
        end
      end
      if (e == 26 + D + 1) begin
        total++;
        if (trig_accept_o !== 1'b1 || trig_buffer_o !== 2'd1) begin
          bad++;
          $display("FAIL accept_after_dead: got acc=%b buf=%0d want 1/1", trig_accept_o, trig_buffer_o);
        end
      end
    end
  endtask

  task automatic test_clear_trig_same_edge();
    fill_all();
    step(1'b0, 1'b1, 4'b0010);
    total++;
    if (trig_reject_o !== 1'b1 || hold_status_o !== 4'b1101) begin
      bad++;
      $display("FAIL same_edge_reject: got rej=%b hold=%b want 1/1101", trig_reject_o, hold_status_o);
    end
    step(1'b0, 1'b1, 4'b0);
    total++;
    if (trig_reject_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL same_edge_retry: got rej=%b busy=%b want 0/1", trig_reject_o, busy_o);
    end
    repeat (D) step(1'b0, 1'b0, 4'b0);
    step(1'b0, 1'b0, 4'b0);
    total++;
    if (trig_accept_o !== 1'b1 || trig_buffer_o !== 2'd1 || hold_status_o !== 4'b1111) begin
      bad++;
      $display("FAIL same_edge_realloc: got acc=%b buf=%0d hold=%b want 1/1/1111", trig_accept_o, trig_buffer_o, hold_status_o);
    end
  endtask

  task automatic test_reset_mid_delay();
    int acc_seen;
    step(1'b1, 1'b0, 4'b0);
    for (int b = 0; b < 2; b++) begin
      step(1'b0, 1'b1, 4'b0);
      repeat (D + T + 1) step(1'b0, 1'b0, 4'b0);
    end
    step(1'b0, 1'b1, 4'b0);
    step(1'b0, 1'b1, 4'b0);
    repeat (3) step(1'b0, 1'b0, 4'b0);
    step(1'b1, 1'b0, 4'b0);
    total++;
    if (HOLD !== '0 || hold_status_o !== 4'b0 || trig_buffer_o !== 2'd0 || reject_count_o !== 16'd0
        || busy_o !== 1'b0 || trig_reject_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_delay: got hold=%b buf=%0d cnt=%0d busy=%b rej=%b want all 0",
               hold_status_o, trig_buffer_o, reject_count_o, busy_o, trig_reject_o);
    end
    acc_seen = 0;
    for (int e = 0; e < D + 4; e++) begin
      step(1'b0, 1'b0, 4'b0);
      if (trig_accept_o === 1'b1) acc_seen++;
    end
    total++;
    if (acc_seen != 0) begin
      bad++;
      $display("FAIL reset_discard: got %0d accept pulses want 0", acc_seen);
    end
    step(1'b0, 1'b1, 4'b0);
    repeat (D) step(1'b0, 1'b0, 4'b0);
    step(1'b0, 1'b0, 4'b0);
    total++;
    if (trig_accept_o !== 1'b1 || trig_buffer_o !== 2'd0 || hold_status_o !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ptr: got acc=%b buf=%0d hold=%b want 1/0/0001", trig_accept_o, trig_buffer_o, hold_status_o);
    end
  endtask

  task automatic test_random();
    logic       rst;
    logic       trg;
    logic [3:0] clr;
    step(1'b1, 1'b0, 4'b0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      trg = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 4; b++) clr[b] = ($urandom_range(0, 79) == 0);
      step(rst, trg, clr);
      total++;
      if ({hold_status_o, HOLD, trig_accept_o, trig_buffer_o, trig_reject_o, busy_o, reject_count_o}
          !== {m_held, {NS{m_held}}, m_accept, m_buf, m_reject, m_busy, m_count}) begin
        bad++;
        $display("FAIL random_c%0d: got hold=%b acc=%b buf=%0d rej=%b busy=%b cnt=%0d want hold=%b acc=%b buf=%0d rej=%b busy=%b cnt=%0d",
                 c, hold_status_o, trig_accept_o, trig_buffer_o, trig_reject_o, busy_o, reject_count_o,
                 m_held, m_accept, m_buf, m_reject, m_busy, m_count);
      end
    end
  endtask

  task automatic test_saturation();
    fill_all();
    for (int c = 0; c < 65540; c++) step(1'b0, 1'b1, 4'b0);
    total++;
    if (reject_count_o !== 16'hFFFF || reject_count_o !== m_count || trig_reject_o !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got cnt=%h rej=%b want ffff/1", reject_count_o, trig_reject_o);
    end
  endtask

  initial begin
    test_reset();
    test_first_trigger();
    test_fill_reject();
    test_clear_realloc();
    test_delay_dead_reject();
    test_clear_trig_same_edge();
    test_reset_mid_delay();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
